// File: rtl/tsv_bus_arbiter_if.sv
// Bus-side signal bundle for the TSV bus arbiter.
// master: the arbiter on the bottom layer (drives grant and header).
// slave : the chip-layer requesters (drive req/done, observe grant and header).
interface tsv_bus_arbiter_if #(
    parameter int NUM_CHIPS = 4
);
    logic [NUM_CHIPS-1:0] req;
    logic [NUM_CHIPS-1:0] done;
    logic [NUM_CHIPS-1:0] grant;
    logic                 bus_busy;
    logic                 hdr_valid;
    logic [31:0]          hdr_data;
    logic [3:0]           owner_id;

    modport master (
        input  req,
        input  done,
        output grant,
        output bus_busy,
        output hdr_valid,
        output hdr_data,
        output owner_id
    );

    modport slave (
        output req,
        output done,
        input  grant,
        input  bus_busy,
        input  hdr_valid,
        input  hdr_data,
        input  owner_id
    );
endinterface

// File: rtl/tsv_bus_arbiter.sv
// Round-robin arbiter for the shared 32-bit inter-layer TSV bus.
// Each tenure is preceded by a one-cycle BEAF-tagged header, limited to
// MAX_BURST grant cycles, and followed by GAP_CYCLES of bus turnaround.
// Optional build macro ARB_STATS_EN adds overrun_cnt (tenures cut off by the
// burst limit without a done).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | sort not finished; bus parked, all outputs low
// ST_ARB   | round-robin search from rr+1 over eligible requesters
// ST_HDR   | one-cycle header frame for the new owner, grant still low
// ST_GRANT | owner holds the bus until done, burst limit or req withdrawal
// ST_GAP   | bus turnaround, grant low for GAP_CYCLES cycles
module tsv_bus_arbiter #(
    parameter int NUM_CHIPS  = 4,
    parameter int MAX_BURST  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sort_finish,
    input  logic [3:0]       chip_count,
`ifdef ARB_STATS_EN
    output logic [7:0]       overrun_cnt,
`endif
    tsv_bus_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_HDR,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t               state_q, state_nxt;
    logic [3:0]           owner_q, owner_nxt;
    logic [3:0]           rr_q, rr_nxt;
    logic [3:0]           burst_q, burst_nxt;
    logic [3:0]           gap_q, gap_nxt;

    logic [NUM_CHIPS-1:0] grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 hdr_valid_q, hdr_valid_d;
    logic [31:0]          hdr_data_q, hdr_data_d;

    logic [4:0]           cc_clamp;
    logic [NUM_CHIPS-1:0] chip_mask;
    logic [NUM_CHIPS-1:0] eligible;
    logic [NUM_CHIPS-1:0] owner_oh;
    logic [NUM_CHIPS-1:0] owner_nxt_oh;
    logic [IDX_W-1:0]     cand;
    logic                 arb_hit;
    logic [3:0]           arb_win;
    logic                 done_own;
    logic                 req_own;
    logic                 burst_last;

    // chip_count above the port count is treated as "all ports present"
    assign cc_clamp   = ({1'b0, chip_count} > 5'(NUM_CHIPS)) ? 5'(NUM_CHIPS) : {1'b0, chip_count};
    assign eligible   = bus.req & chip_mask;
    assign done_own   = |(bus.done & owner_oh);
    assign req_own    = |(bus.req & owner_oh);
    assign burst_last = (burst_q == 4'(MAX_BURST - 1));

    // Decode of the present owner and of the valid-layer mask
    always_comb begin
        owner_oh  = '0;
        chip_mask = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            owner_oh[i]  = (owner_q == 4'(i));
            chip_mask[i] = (5'(i) < cc_clamp);
        end
    end

    // Round-robin search: first eligible requester after the last winner
    always_comb begin
        arb_hit = 1'b0;
        arb_win = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_CHIPS; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_CHIPS);
            if (!arb_hit && eligible[cand]) begin
                arb_hit = 1'b1;
                arb_win = 4'(cand);
            end
        end
    end

    // Next-state and counter update; losing sort_finish overrides everything
    always_comb begin
        state_nxt = state_q;
        owner_nxt = owner_q;
        rr_nxt    = rr_q;
        burst_nxt = burst_q;
        gap_nxt   = gap_q;
        if (!sort_finish) begin
            state_nxt = ST_IDLE;
            burst_nxt = '0;
            gap_nxt   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_nxt = ST_ARB;
                ST_ARB: begin
                    if (arb_hit) begin
                        state_nxt = ST_HDR;
                        owner_nxt = arb_win;
                        rr_nxt    = arb_win;
                    end
                end
                ST_HDR: begin
                    state_nxt = ST_GRANT;
                    burst_nxt = '0;
                end
                ST_GRANT: begin
                    // done, burst limit and withdrawal collapse into one exit
                    if (done_own || burst_last || !req_own) begin
                        state_nxt = ST_GAP;
                        burst_nxt = '0;
                        gap_nxt   = 4'(GAP_CYCLES - 1);
                    end else begin
                        burst_nxt = burst_q + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 4'd0) begin
                        state_nxt = ST_ARB;
                    end else begin
                        gap_nxt = gap_q - 4'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output values for the coming cycle, so every output leaves a flop
    always_comb begin
        owner_nxt_oh = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            owner_nxt_oh[i] = (owner_nxt == 4'(i));
        end
        grant_d     = '0;
        busy_d      = 1'b0;
        hdr_valid_d = 1'b0;
        hdr_data_d  = '0;
        case (state_nxt)
            ST_HDR: begin
                busy_d      = 1'b1;
                hdr_valid_d = 1'b1;
                hdr_data_d  = {4'b1010, 8'h00, owner_nxt, 16'hBEAF};
            end
            ST_GRANT: begin
                busy_d  = 1'b1;
                grant_d = owner_nxt_oh;
            end
            ST_GAP:  busy_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // State, counters and registered outputs; reset clears grant at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_q        <= 4'(NUM_CHIPS - 1);
            burst_q     <= '0;
            gap_q       <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
        end else begin
            state_q     <= state_nxt;
            owner_q     <= owner_nxt;
            rr_q        <= rr_nxt;
            burst_q     <= burst_nxt;
            gap_q       <= gap_nxt;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.bus_busy  = busy_q;
    assign bus.hdr_valid = hdr_valid_q;
    assign bus.hdr_data  = hdr_data_q;
    assign bus.owner_id  = owner_q;

`ifdef ARB_STATS_EN
    logic sort_q;
    logic overrun_evt;

    // Burst-limit exit without done; a simultaneous done is a normal end
    assign overrun_evt = (state_q == ST_GRANT) && sort_finish && burst_last && !done_own;

    // Saturating overrun counter, cleared when sort_finish falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sort_q      <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            sort_q <= sort_finish;
            if (sort_q && !sort_finish) begin
                overrun_cnt <= '0;
            end else if (overrun_evt && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end
`else
    // Statistics build option not selected: no overrun tracking.
`endif

endmodule

// File: tb/tb_tsv_bus_arbiter.sv
// Scoreboard bench for tsv_bus_arbiter: stimulus queues expected headers
// and tenures, a negedge monitor pops and compares them as they appear.
module tb_tsv_bus_arbiter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sort_finish = 1'b0;
    logic [3:0] chip_count = 4'd0;
`ifdef ARB_STATS_EN
    logic [7:0] overrun_cnt;
`endif

    tsv_bus_arbiter_if #(.NUM_CHIPS(N)) bus ();

    tsv_bus_arbiter #(
        .NUM_CHIPS(N),
        .MAX_BURST(8),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sort_finish(sort_finish),
        .chip_count(chip_count),
`ifdef ARB_STATS_EN
        .overrun_cnt(overrun_cnt),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] owner;
        int         len;
        int         gap;
    } ten_t;

    logic [31:0] hdr_q[$];
    ten_t        ten_q[$];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_hdr(input logic [3:0] owner);
        hdr_q.push_back({4'b1010, 8'h00, owner, 16'hBEAF});
    endtask

    task automatic exp_tenure(input logic [3:0] owner, input int len, input int gap);
        ten_t t;
        t.owner = owner;
        t.len   = len;
        t.gap   = gap;
        ten_q.push_back(t);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for a fresh grant: grant low first, then high
    task automatic wait_grant(input string name);
        bit seen_low;
        bit ok;
        seen_low = (bus.grant == '0);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step(1);
            if (!seen_low) begin
                if (bus.grant == '0) seen_low = 1'b1;
            end else if (bus.grant != '0) begin
                ok = 1'b1;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    function automatic logic [3:0] oh2id(input logic [N-1:0] oh);
        logic [3:0] id;
        id = 4'hF;
        for (int i = 0; i < N; i++) if (oh[i]) id = 4'(i);
        return id;
    endfunction

    // ---------------- monitor ----------------
    bit          in_ten = 1'b0;
    bit          in_gap = 1'b0;
    bit          prev_hdr = 1'b0;
    int          ten_len = 0;
    int          gap_len = 0;
    int          exp_gap = 0;
    logic [3:0]  ten_owner = '0;
    logic [31:0] exp_word;
    ten_t        t_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_ten   = 1'b0;
            in_gap   = 1'b0;
            prev_hdr = 1'b0;
        end else begin
            check("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
            if (bus.hdr_valid) begin
                check("grant_low_in_hdr", 32'(bus.grant), 32'd0);
                if (hdr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_hdr: got %0h expected no header", bus.hdr_data);
                end else begin
                    exp_word = hdr_q.pop_front();
                    check("hdr_data", bus.hdr_data, exp_word);
                    check("hdr_owner", 32'(bus.owner_id), 32'(exp_word[19:16]));
                end
            end
            if (bus.grant != '0) begin
                if (!in_ten) begin
                    in_ten    = 1'b1;
                    ten_len   = 1;
                    ten_owner = oh2id(bus.grant);
                    check("hdr_before_grant", 32'(prev_hdr), 32'd1);
                end else begin
                    ten_len++;
                end
            end else if (in_ten) begin
                in_ten = 1'b0;
                if (ten_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tenure: got owner %0d len %0d expected none", ten_owner, ten_len);
                end else begin
                    t_exp = ten_q.pop_front();
                    check("ten_owner", 32'(ten_owner), 32'(t_exp.owner));
                    check("ten_len", ten_len, t_exp.len);
                    if (bus.bus_busy && !bus.hdr_valid) begin
                        in_gap  = 1'b1;
                        gap_len = 1;
                        exp_gap = t_exp.gap;
                    end else begin
                        gap_len = 0;
                        check("gap_len", gap_len, t_exp.gap);
                    end
                end
            end else if (in_gap) begin
                if (bus.bus_busy && !bus.hdr_valid) begin
                    gap_len++;
                end else begin
                    in_gap = 1'b0;
                    check("gap_len", gap_len, exp_gap);
                end
            end
            prev_hdr = bus.hdr_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit idle_ok;
        bus.req  = '0;
        bus.done = '0;

        // Reset state
        step(2);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.bus_busy), 32'd0);
        check("rst_hdr_valid", 32'(bus.hdr_valid), 32'd0);
        check("rst_hdr_data", bus.hdr_data, 32'd0);
        check("rst_owner", 32'(bus.owner_id), 32'd0);
        rst_n = 1'b1;
        step(1);

        // 1: single requester, done on the 3rd grant cycle
        exp_hdr(4'd0);
        exp_tenure(4'd0, 3, 2);
        sort_finish = 1'b1;
        chip_count  = 4'd4;
        bus.req     = 4'b0001;
        wait_grant("t1_wait_grant");
        step(2);
        bus.done = 4'b0001;
        step(1);
        bus.done = 4'b0000;
        bus.req  = 4'b0000;
        step(4);
        check("t1_idle_busy", 32'(bus.bus_busy), 32'd0);

        // 2: all four requesting from reset, burst limit ends every tenure
        rst_n = 1'b0;
        step(2);
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        exp_hdr(4'd0); exp_tenure(4'd0, 8, 2);
        exp_hdr(4'd1); exp_tenure(4'd1, 8, 2);
        exp_hdr(4'd2); exp_tenure(4'd2, 8, 2);
        exp_hdr(4'd3); exp_tenure(4'd3, 8, 2);
        exp_hdr(4'd0); exp_tenure(4'd0, 8, 2);
        for (int k = 0; k < 5; k++) wait_grant("t2_wait_grant");
        step(8);
        bus.req = 4'b0000;
        step(4);
`ifdef ARB_STATS_EN
        check("t2_overrun_cnt", 32'(overrun_cnt), 32'd5);
`endif

        // 3: requesters outside chip_count are never granted
        chip_count = 4'd2;
        bus.req    = 4'b1100;
        idle_ok    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.bus_busy !== 1'b0 || bus.grant !== '0) idle_ok = 1'b0;
        end
        check("t3_masked_idle", 32'(idle_ok), 32'd1);
        exp_hdr(4'd2);
        exp_tenure(4'd2, 1, 2);
        chip_count = 4'd4;
        wait_grant("t3_wait_grant");
        bus.done = 4'b0100;
        step(1);
        bus.done = 4'b0000;
        bus.req  = 4'b0000;
        step(4);

        // 4: sort_finish drops during chip 1's tenure, rr is kept
        exp_hdr(4'd1);
        exp_tenure(4'd1, 2, 0);
        bus.req = 4'b0010;
        wait_grant("t4_wait_grant");
        step(1);
        sort_finish = 1'b0;
        step(1);
        check("t4_grant_drop", 32'(bus.grant), 32'd0);
        check("t4_busy_drop", 32'(bus.bus_busy), 32'd0);
        check("t4_owner_kept", 32'(bus.owner_id), 32'd1);
`ifdef ARB_STATS_EN
        check("t4_overrun_clr", 32'(overrun_cnt), 32'd0);
`endif
        step(2);
        exp_hdr(4'd0);
        exp_tenure(4'd0, 1, 2);
        bus.req     = 4'b0011;
        sort_finish = 1'b1;
        wait_grant("t4_wait_regrant");
        bus.done = 4'b0001;
        step(1);
        bus.done = 4'b0000;
        bus.req  = 4'b0000;
        step(4);

        // 5: owner 3 withdraws on its 2nd cycle; chip 2 waits a full gap
        exp_hdr(4'd3);
        exp_tenure(4'd3, 2, 2);
        exp_hdr(4'd2);
        exp_tenure(4'd2, 1, 2);
        bus.req = 4'b1000;
        wait_grant("t5_wait_grant");
        step(1);
        bus.req = 4'b0100;
        wait_grant("t5_wait_next");
        bus.done = 4'b0100;
        step(1);
        bus.done = 4'b0000;
        bus.req  = 4'b0000;
        step(4);

        // 6: asynchronous reset in the middle of a tenure
        exp_hdr(4'd0);
        bus.req = 4'b0001;
        wait_grant("t6_wait_grant");
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_grant", 32'(bus.grant), 32'd0);
        check("t6_async_hdr", 32'(bus.hdr_valid), 32'd0);
        check("t6_async_busy", 32'(bus.bus_busy), 32'd0);
        bus.req     = 4'b0000;
        sort_finish = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        check("t6_owner_rst", 32'(bus.owner_id), 32'd0);
        check("t6_idle_grant", 32'(bus.grant), 32'd0);
        check("t6_idle_busy", 32'(bus.bus_busy), 32'd0);
        check("t6_idle_hdr", bus.hdr_data, 32'd0);

        step(3);
        check("hdr_queue_drained", hdr_q.size(), 32'd0);
        check("tenure_queue_drained", ten_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
